// File: rtl/traffic_pkg.sv
// Shared light encodings, fault bit indices and timing defaults for the
// intersection signal monitor.
package traffic_pkg;

  typedef enum logic [1:0] {
    LIGHT_RED     = 2'b00,
    LIGHT_YELLOW  = 2'b01,
    LIGHT_GREEN   = 2'b10,
    LIGHT_ILLEGAL = 2'b11
  } light_e;

  localparam int FLT_CONFLICT     = 0;
  localparam int FLT_ILLEGAL_CODE = 1;
  localparam int FLT_BAD_SEQ      = 2;
  localparam int FLT_YELLOW_LEN   = 3;
  localparam int FLT_GREEN_SHORT  = 4;
  localparam int FLT_STARVE       = 5;
  localparam int NUM_FAULTS       = 6;

  localparam int DEF_YELLOW_CYCLES = 4;
  localparam int DEF_GREEN_MIN     = 6;
  localparam int DEF_MAX_RED       = 32;
  localparam int DEF_CNT_W         = 16;

  // Run counters are 8 bits and stick at all-ones.
  localparam int RUN_W = 8;
  typedef logic [RUN_W-1:0] run_t;
  localparam run_t RUN_SAT = '1;

  // Lowest set fault index plus one; zero when nothing is set.
  function automatic logic [2:0] first_fault_code(input logic [NUM_FAULTS-1:0] hits);
    logic [2:0] code;
    code = '0;
    for (int i = NUM_FAULTS - 1; i >= 0; i--) begin
      if (hits[i]) code = 3'(i + 1);
    end
    return code;
  endfunction

endpackage

// File: rtl/traffic_phase_monitor_if.sv
// Light/pedestrian bus between the intersection controller and its monitor.
// No valid/ready handshake: the controller (master) drives every signal every
// cycle and the monitor (slave) samples all of them on every rising edge.
interface traffic_phase_monitor_if;
  logic [1:0] light_NS;
  logic [1:0] light_EW;
  logic       pred_signal_NS;
  logic       pred_signal_EW;

  modport master (output light_NS, output light_EW,
                  output pred_signal_NS, output pred_signal_EW);
  modport slave  (input light_NS, input light_EW,
                  input pred_signal_NS, input pred_signal_EW);
endinterface

// File: rtl/traffic_phase_monitor_phase_tracker.sv
// Per-direction sequence tracker: remembers the previous light code and how
// long it has been held, and flags illegal transitions and bad run lengths.
module phase_tracker
  import traffic_pkg::*;
#(
  parameter int YELLOW_CYCLES = DEF_YELLOW_CYCLES,
  parameter int GREEN_MIN     = DEF_GREEN_MIN,
  parameter int MAX_RED       = DEF_MAX_RED
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       sample_valid,
  input  logic [1:0] code,
  input  logic       pred_signal,
  output logic       seq_err,
  output logic       yellow_err,
  output logic       green_short,
  output logic       starve,
  output logic       green_rise,
  output logic       red_to_green
);

  localparam run_t YEL_LEN   = run_t'(YELLOW_CYCLES);
  localparam run_t GRN_MIN   = run_t'(GREEN_MIN);
  localparam run_t RED_LIMIT = run_t'(MAX_RED);

  logic [1:0] prev_q;
  logic       prev_valid_q;
  run_t       run_q;
  logic       is_change;
  logic       is_hold;

  // Classify the current sample against the stored run. Transitions into or
  // out of the illegal code are never judged as sequence or length errors.
  always_comb begin
    is_change    = sample_valid && prev_valid_q && (code != LIGHT_ILLEGAL) && (code != prev_q);
    is_hold      = sample_valid && prev_valid_q && (code == prev_q);
    seq_err      = (sample_valid && pred_signal && (code != LIGHT_GREEN)) ||
                   (is_change && (((prev_q == LIGHT_RED) && (code == LIGHT_YELLOW)) ||
                                  ((prev_q == LIGHT_YELLOW) && (code == LIGHT_GREEN))));
    yellow_err   = is_change && (prev_q == LIGHT_YELLOW) && (run_q != YEL_LEN);
    green_short  = is_change && (prev_q == LIGHT_GREEN) && (run_q != RUN_SAT) && (run_q < GRN_MIN);
    // The red run only passes through MAX_RED once, so this fires once per run.
    starve       = is_hold && (code == LIGHT_RED) && (run_q == RED_LIMIT);
    green_rise   = is_change && (code == LIGHT_GREEN);
    red_to_green = is_change && (prev_q == LIGHT_RED) && (code == LIGHT_GREEN);
  end

  // Track previous code and saturating run length; an illegal code breaks the run.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      prev_q       <= LIGHT_RED;
      prev_valid_q <= 1'b0;
      run_q        <= '0;
    end else if (sample_valid) begin
      if (code == LIGHT_ILLEGAL) begin
        prev_q       <= code;
        prev_valid_q <= 1'b0;
        run_q        <= '0;
      end else if (!prev_valid_q || (code != prev_q)) begin
        prev_q       <= code;
        prev_valid_q <= 1'b1;
        run_q        <= run_t'(1);
      end else if (run_q != RUN_SAT) begin
        run_q <= run_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_phase_monitor.sv
// Passive safety/sequence monitor on the controller's light outputs. Inputs
// are registered first; checks run on that registered sample, so a violation
// in the sample taken at edge N is visible after edge N+1.
module traffic_phase_monitor
  import traffic_pkg::*;
#(
  parameter int YELLOW_CYCLES = DEF_YELLOW_CYCLES,
  parameter int GREEN_MIN     = DEF_GREEN_MIN,
  parameter int MAX_RED       = DEF_MAX_RED,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  traffic_phase_monitor_if.slave lif,
  input  logic                  clear,
  output logic                  fault,
  output logic [NUM_FAULTS-1:0] fault_bits,
  output logic [2:0]            first_fault,
  output logic [CNT_W-1:0]      cycle_count
);

  logic [1:0] ns_q, ew_q;
  logic       pns_q, pew_q, sample_valid_q;
  logic       ns_seq, ns_yel, ns_grn, ns_stv, ns_rise, ns_r2g;
  logic       ew_seq, ew_yel, ew_grn, ew_stv, ew_rise, ew_r2g_unused;
  logic       ew_seen_q;
  logic [NUM_FAULTS-1:0] hits;

  // Register the bus; reset or clear marks the sample register empty.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      ns_q           <= LIGHT_RED;
      ew_q           <= LIGHT_RED;
      pns_q          <= 1'b0;
      pew_q          <= 1'b0;
      sample_valid_q <= 1'b0;
    end else begin
      ns_q           <= lif.light_NS;
      ew_q           <= lif.light_EW;
      pns_q          <= lif.pred_signal_NS;
      pew_q          <= lif.pred_signal_EW;
      sample_valid_q <= 1'b1;
    end
  end

  phase_tracker #(.YELLOW_CYCLES(YELLOW_CYCLES), .GREEN_MIN(GREEN_MIN), .MAX_RED(MAX_RED)) u_ns (
    .clk(clk), .reset_n(reset_n), .clear(clear), .sample_valid(sample_valid_q),
    .code(ns_q), .pred_signal(pns_q),
    .seq_err(ns_seq), .yellow_err(ns_yel), .green_short(ns_grn), .starve(ns_stv),
    .green_rise(ns_rise), .red_to_green(ns_r2g)
  );

  phase_tracker #(.YELLOW_CYCLES(YELLOW_CYCLES), .GREEN_MIN(GREEN_MIN), .MAX_RED(MAX_RED)) u_ew (
    .clk(clk), .reset_n(reset_n), .clear(clear), .sample_valid(sample_valid_q),
    .code(ew_q), .pred_signal(pew_q),
    .seq_err(ew_seq), .yellow_err(ew_yel), .green_short(ew_grn), .starve(ew_stv),
    .green_rise(ew_rise), .red_to_green(ew_r2g_unused)
  );

  // Merge the per-sample fault indications from both directions.
  always_comb begin
    hits = '0;
    hits[FLT_CONFLICT]     = sample_valid_q && (ns_q != LIGHT_RED) && (ew_q != LIGHT_RED);
    hits[FLT_ILLEGAL_CODE] = sample_valid_q && ((ns_q == LIGHT_ILLEGAL) || (ew_q == LIGHT_ILLEGAL));
    hits[FLT_BAD_SEQ]      = ns_seq || ew_seq;
    hits[FLT_YELLOW_LEN]   = ns_yel || ew_yel;
    hits[FLT_GREEN_SHORT]  = ns_grn || ew_grn;
    hits[FLT_STARVE]       = ns_stv || ew_stv;
  end

  // Sticky fault bits; first_fault latches the lowest new index once.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      fault_bits  <= '0;
      first_fault <= '0;
    end else begin
      fault_bits <= fault_bits | hits;
      if (first_fault == '0) first_fault <= first_fault_code(hits);
    end
  end

  assign fault = |fault_bits;

  // Count NS red-to-green entries that were preceded by an EW green entry
  // since the last NS green entry.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      cycle_count <= '0;
      ew_seen_q   <= 1'b0;
    end else begin
      if (ns_r2g && ew_seen_q && (cycle_count != '1)) cycle_count <= cycle_count + 1'b1;
      if (ns_rise)      ew_seen_q <= 1'b0;
      else if (ew_rise) ew_seen_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_traffic_phase_monitor.sv
// Bench for traffic_phase_monitor: directed scenarios plus randomized light
// rotations with injected faults, checked against a history-based model.
module tb_traffic_phase_monitor;

  localparam int CNT_W = 16;
  localparam int EXP_W = 1 + 6 + 3 + CNT_W;
  localparam int YEL   = 4;
  localparam int GMIN  = 6;
  localparam int MAXR  = 32;
  localparam logic [1:0] R = 2'b00, Y = 2'b01, G = 2'b10, X = 2'b11;

  logic             clk;
  logic             reset_n;
  logic             clear;
  logic             fault;
  logic [5:0]       fault_bits;
  logic [2:0]       first_fault;
  logic [CNT_W-1:0] cycle_count;

  traffic_phase_monitor_if lif();

  traffic_phase_monitor #(.YELLOW_CYCLES(YEL), .GREEN_MIN(GMIN), .MAX_RED(MAXR), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .lif(lif), .clear(clear),
    .fault(fault), .fault_bits(fault_bits), .first_fault(first_fault), .cycle_count(cycle_count)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (sample history) ----------------
  int hn[$];
  int he[$];
  logic [5:0]       m_bits;
  logic [2:0]       m_ff;
  logic [CNT_W-1:0] m_cc;
  logic [5:0]       pend_err;
  logic             pend_inc;
  logic [EXP_W-1:0] exp_q[$];

  function automatic int code_at(input int dir, input int k);
    return (dir == 0) ? hn[k] : he[k];
  endfunction

  // Length of the run of identical codes ending at k, capped at 255.
  function automatic int run_len(input int dir, input int k);
    int n;
    int c;
    n = 0;
    c = code_at(dir, k);
    for (int m = k; m >= 0 && n < 255; m--) begin
      if (code_at(dir, m) != c) break;
      n++;
    end
    return n;
  endfunction

  function automatic bit green_entry(input int dir, input int m);
    if (m == 0) return 1'b0;
    return code_at(dir, m - 1) != 2 && code_at(dir, m - 1) != 3 && code_at(dir, m) == 2;
  endfunction

  function automatic bit ew_seen_before(input int k);
    for (int m = k - 1; m >= 0; m--) begin
      if (green_entry(0, m)) return 1'b0;
      if (green_entry(1, m)) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic classify(input logic pns, input logic pew);
    int k;
    int c;
    int pc;
    int r;
    logic p;
    logic [5:0] e;
    k = hn.size() - 1;
    e = '0;
    if (hn[k] != 0 && he[k] != 0) e[0] = 1'b1;
    if (hn[k] == 3 || he[k] == 3) e[1] = 1'b1;
    for (int dir = 0; dir < 2; dir++) begin
      c = code_at(dir, k);
      p = (dir == 0) ? pns : pew;
      if (p && c != 2) e[2] = 1'b1;
      if (k > 0) begin
        pc = code_at(dir, k - 1);
        if (pc != 3 && c != 3 && c != pc) begin
          r = run_len(dir, k - 1);
          if ((pc == 0 && c == 1) || (pc == 1 && c == 2)) e[2] = 1'b1;
          if (pc == 1 && r != YEL) e[3] = 1'b1;
          if (pc == 2 && r < 255 && r < GMIN) e[4] = 1'b1;
        end
      end
      if (c == 0 && run_len(dir, k) == MAXR + 1) e[5] = 1'b1;
    end
    pend_err = e;
    pend_inc = (k > 0) && hn[k - 1] == 0 && hn[k] == 2 && ew_seen_before(k);
  endtask

  // Outputs after the coming edge: the previous sample's findings land, and
  // the sample being driven now joins the history.
  task automatic model_edge(input logic rn, input logic clr, input logic [1:0] ns,
                            input logic [1:0] ew, input logic pns, input logic pew);
    if (!rn || clr) begin
      hn.delete();
      he.delete();
      m_bits   = '0;
      m_ff     = '0;
      m_cc     = '0;
      pend_err = '0;
      pend_inc = 1'b0;
    end else begin
      if (m_ff == 0) begin
        for (int i = 5; i >= 0; i--) if (pend_err[i]) m_ff = 3'(i + 1);
      end
      m_bits = m_bits | pend_err;
      if (pend_inc && m_cc != '1) m_cc = m_cc + 1'b1;
      hn.push_back(int'(ns));
      he.push_back(int'(ew));
      classify(pns, pew);
    end
    exp_q.push_back({|m_bits, m_bits, m_ff, m_cc});
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic rn, input logic clr, input logic [1:0] ns,
                      input logic [1:0] ew, input logic pns, input logic pew);
    logic [EXP_W-1:0] e;
    reset_n            = rn;
    clear              = clr;
    lif.light_NS       = ns;
    lif.light_EW       = ew;
    lif.pred_signal_NS = pns;
    lif.pred_signal_EW = pew;
    model_edge(rn, clr, ns, ew, pns, pew);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("fault",       32'(fault),       32'(e[CNT_W+9]));
    check_eq("fault_bits",  32'(fault_bits),  32'(e[CNT_W+8:CNT_W+3]));
    check_eq("first_fault", 32'(first_fault), 32'(e[CNT_W+2:CNT_W]));
    check_eq("cycle_count", 32'(cycle_count), 32'(e[CNT_W-1:0]));
  endtask

  task automatic phase(input logic [1:0] ns, input logic [1:0] ew, input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, ns, ew, 1'b0, 1'b0);
  endtask

  task automatic do_clear();
    step(1'b1, 1'b1, R, R, 1'b0, 1'b0);
  endtask

  task automatic rnd_phase(input logic [1:0] ns, input logic [1:0] ew, input int n);
    logic [1:0] a;
    logic [1:0] b;
    logic pa;
    logic pb;
    logic c;
    logic rn;
    for (int i = 0; i < n; i++) begin
      a = ns;
      b = ew;
      if ($urandom_range(0, 59) == 0) a = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) b = 2'($urandom_range(0, 3));
      pa = (a == G) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 49) == 0);
      pb = (b == G) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 49) == 0);
      c  = ($urandom_range(0, 299) == 0);
      rn = ($urandom_range(0, 499) != 0);
      step(rn, c, a, b, pa, pb);
    end
  endtask

  task automatic random_rounds(input int n);
    for (int r = 0; r < n; r++) begin
      if ($urandom_range(0, 9) == 0) begin
        rnd_phase(R, R, $urandom_range(25, 40));
      end else begin
        rnd_phase(G, R, $urandom_range(3, 14));
        rnd_phase(Y, R, $urandom_range(3, 5));
        rnd_phase(R, G, $urandom_range(3, 14));
        rnd_phase(R, Y, $urandom_range(3, 5));
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0;
    clear = 1'b0;
    lif.light_NS = R;
    lif.light_EW = R;
    lif.pred_signal_NS = 1'b0;
    lif.pred_signal_EW = 1'b0;

    // reset state
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, R, R, 1'b0, 1'b0);
    check_eq("rst_bits", 32'(fault_bits), 32'd0);
    check_eq("rst_ff",   32'(first_fault), 32'd0);
    check_eq("rst_cc",   32'(cycle_count), 32'd0);

    // nominal rotations, closed by a final NS green entry
    for (int r = 0; r < 3; r++) begin
      phase(G, R, 11); phase(Y, R, 4); phase(R, G, 11); phase(R, Y, 4);
    end
    phase(G, R, 2);
    check_eq("nom_fault", 32'(fault), 32'd0);
    check_eq("nom_ff",    32'(first_fault), 32'd0);
    check_eq("nom_cc",    32'(cycle_count), 32'd3);

    // single-sample conflict, one cycle of latency, sticky afterwards
    do_clear();
    phase(G, R, 8);
    step(1'b1, 1'b0, G, Y, 1'b0, 1'b0);
    check_eq("cf_latency", 32'(fault_bits[0]), 32'd0);
    phase(G, R, 1);
    check_eq("cf_bit", 32'(fault_bits[0]), 32'd1);
    check_eq("cf_ff",  32'(first_fault), 32'd1);
    phase(G, R, 3);
    check_eq("cf_hold", 32'(fault_bits[0]), 32'd1);

    // yellow too short, then too long
    for (int len = 3; len <= 5; len += 2) begin
      do_clear();
      phase(G, R, 8); phase(Y, R, len); phase(R, R, 2);
      check_eq("yl_bits", 32'(fault_bits), 32'h08);
      check_eq("yl_ff",   32'(first_fault), 32'd4);
    end

    // red to yellow, then pedestrian walk against red
    do_clear();
    phase(R, R, 3); phase(Y, R, 4); phase(R, R, 1);
    step(1'b1, 1'b0, R, R, 1'b0, 1'b1);
    phase(R, R, 2);
    check_eq("bs_bit", 32'(fault_bits[2]), 32'd1);
    check_eq("bs_ff",  32'(first_fault), 32'd3);
    do_clear();
    phase(R, R, 2);
    step(1'b1, 1'b0, R, R, 1'b0, 1'b1);
    phase(R, R, 1);
    check_eq("ped_bits", 32'(fault_bits), 32'h04);

    // EW red for 33 samples
    do_clear();
    phase(G, R, 33);
    check_eq("stv_early", 32'(fault_bits[5]), 32'd0);
    phase(G, R, 1);
    check_eq("stv_bits", 32'(fault_bits), 32'h20);
    check_eq("stv_ff",   32'(first_fault), 32'd6);
    do_clear();
    check_eq("clr_fault", 32'(fault), 32'd0);
    check_eq("clr_bits",  32'(fault_bits), 32'd0);
    check_eq("clr_ff",    32'(first_fault), 32'd0);

    // illegal code together with a conflict
    phase(G, R, 6);
    step(1'b1, 1'b0, X, G, 1'b0, 1'b0);
    phase(R, G, 1);
    check_eq("il_b0", 32'(fault_bits[0]), 32'd1);
    check_eq("il_b1", 32'(fault_bits[1]), 32'd1);
    check_eq("il_ff", 32'(first_fault), 32'd1);

    // reset in the middle of a yellow run, then a clean 4-cycle yellow
    phase(G, R, 8); phase(Y, R, 2);
    step(1'b0, 1'b0, Y, R, 1'b0, 1'b0);
    phase(Y, R, 4); phase(R, R, 3);
    check_eq("rmy_fault", 32'(fault), 32'd0);

    // randomized rotations with injected faults, clears and resets
    random_rounds(50);
    phase(R, R, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/traffic_phase_monitor.md
Name: traffic_phase_monitor

Overview:
- Passive checker on the light/pedestrian outputs of the intersection controller; it is the receiving end of the light interface.
- Samples light_NS/light_EW and pred_signal_NS/pred_signal_EW every cycle and flags safety and sequencing violations.
- Keeps sticky fault bits, records the first fault, and counts completed cycles of the signal sequence.
- Sits beside the controller in the top level and in the testbench; it drives nothing back into the controller.

Parameters:
- YELLOW_CYCLES, 4, required length of every yellow run in cycles.
- GREEN_MIN, 6, minimum length of a green run in cycles.
- MAX_RED, 32, longest legal red run per direction in cycles.
- CNT_W, 16, width of the cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous active-low reset.
- light_NS  in  2  NS light code: 00 red, 01 yellow, 10 green, 11 illegal.
- light_EW  in  2  EW light code, same encoding.
- pred_signal_NS  in  1  NS pedestrian walk indication.
- pred_signal_EW  in  1  EW pedestrian walk indication.
- clear  in  1  synchronous clear of the sticky faults, first_fault and the counter.
- fault  out  1  OR of fault_bits.
- fault_bits  out  6  sticky bits: [0] CONFLICT, [1] ILLEGAL_CODE, [2] BAD_SEQ, [3] YELLOW_LEN, [4] GREEN_SHORT, [5] STARVE.
- first_fault  out  3  index of the first fault bit set, plus 1 (0 = none).
- cycle_count  out  CNT_W  completed NS-green-to-EW-green-to-NS-green rotations, saturating.

Behaviour:
- Reset (reset_n=0 at a clk edge): all outputs 0, run counters 0, prev_valid=0. Reset mid-run discards partial runs.
- clear=1 has the same effect as reset on the outputs and counters. reset_n takes precedence over clear.
- Latency: a violation present in the sample at edge N sets its bit after edge N+1 (registered check of the registered sample). Bits hold until reset or clear.
- Per-direction tracker:
  - Holds prev code, a run counter that saturates at 255, and red_run.
  - While the code is unchanged, run increments. On a code change, the old run is checked, then run reloads to 1.
- CONFLICT: both directions not red in the same sample.
- ILLEGAL_CODE: either code is 11. An 11 sample resets that tracker's prev_valid, so no sequence check is made against it.
- BAD_SEQ, only when prev_valid=1:
  - red to yellow, or yellow to green, is illegal.
  - green to yellow, yellow to red, red to green and green to red are legal.
  - green to red is the emergency pre-emption path and is allowed.
- YELLOW_LEN: on yellow to any other code, the yellow run must equal YELLOW_CYCLES exactly.
- GREEN_SHORT: on green exit, a run below GREEN_MIN is a fault. A green run of 255 (saturated) is not checked.
- STARVE: set when red_run reaches MAX_RED+1. It fires once per red run.
- Pedestrian violation: pred_signal_X=1 while light_X is not green sets BAD_SEQ.
- first_fault: loaded only while it is 0.
  - If several bits set in the same cycle, the lowest index wins.
  - Value = index+1 (CONFLICT gives 1, STARVE gives 6).
- cycle_count: increments on an NS red to green edge that follows at least one EW green since the previous NS green. It saturates at all-ones.
- The first sample after reset or clear only loads prev; no run checks are made on it.

Decomposition:
- Package traffic_pkg holds:
  - the light encodings (LIGHT_RED, LIGHT_YELLOW, LIGHT_GREEN, LIGHT_ILLEGAL);
  - the fault bit indices (FLT_CONFLICT through FLT_STARVE);
  - the shared timing constants.
- Sub-module phase_tracker, instantiated once per direction:
  - inputs: code, pred_signal, clear;
  - outputs: seq_err, yellow_err, green_short, starve, green_rise, and the prev_valid-qualified edge pulses.
- The top level does conflict detection, fault merging, first-fault priority and cycle_count.

Test Plan:
- Nominal sequence (NS green 11 cycles, yellow 4, EW green 11, yellow 4, repeated 3 times) -> fault=0, first_fault=0, cycle_count=3.
- light_NS=10 and light_EW=01 in a single sample -> fault_bits[0]=1 one cycle later, first_fault=1, and both stay set after the inputs return to legal.
- NS yellow run of 3 cycles, then red -> fault_bits[3]=1 and first_fault=4. A 5-cycle yellow gives the same result.
- NS red to yellow transition, then pred_signal_EW=1 with EW red -> fault_bits[2]=1, and first_fault=3 from the first event.
- EW held red for 33 cycles -> fault_bits[5]=1 after the 33rd red sample, asserted exactly once. Then clear=1 -> all outputs 0.
- light_NS=11 in the same cycle as a conflict -> bits[0] and [1] set, first_fault=1. Asserting reset_n=0 mid-yellow clears everything, and the following 4-cycle yellow raises no fault.
